mem_arbiter: RTL and testbench

- Two-port arbiter sharing the single external DRAM interface (256-bit line, cs/we/ack handshake) between the instruction-fetch path (port 0) and the L1 data cache controller (port 1).
- Sits between the CPU-internal requesters and the CPU's ext_mem_* pins.
- Serialises line reads and write-backs, one outstanding transaction at a time, and returns each ack and read line only to the port that was granted.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding and port indices for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DCACHE = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port DRAM line arbiter, one outstanding transaction
// Optional: define MEM_ARB_ROUND_ROBIN_EN for alternating grants on a tie.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [DATA_WIDTH-1:0] p0_data_i,
    input  logic                  p0_cs_i,
    input  logic                  p0_we_i,
    output logic [DATA_WIDTH-1:0] p0_data_o,
    output logic                  p0_ack_o,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_data_i,
    input  logic                  p1_cs_i,
    input  logic                  p1_we_i,
    output logic [DATA_WIDTH-1:0] p1_data_o,
    output logic                  p1_ack_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_cs_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  mem_ack_i,
    output logic                  busy_o
);
    import mem_arb_pkg::*;

    arb_state_e            state_q;
    logic                  grant_q;
    logic                  grant_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  mem_cs_q;
    logic                  mem_we_q;
    logic [DATA_WIDTH-1:0] p0_data_q;
    logic [DATA_WIDTH-1:0] p1_data_q;
    logic                  p0_ack_q;
    logic                  p1_ack_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  last_q;
`endif

    // Winner among the ports requesting this cycle; only used in IDLE.
    always_comb begin
        grant_d = PORT_IFETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (p0_cs_i && p1_cs_i) begin
            grant_d = ~last_q;
        end else if (p1_cs_i) begin
            grant_d = PORT_DCACHE;
        end
`else
        if (!p0_cs_i && p1_cs_i) begin
            grant_d = PORT_DCACHE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= PORT_IFETCH;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            p0_data_q  <= '0;
            p1_data_q  <= '0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= PORT_DCACHE;
`endif
        end else begin
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (p0_cs_i || p1_cs_i) begin
                        grant_q    <= grant_d;
                        mem_addr_q <= grant_d ? p1_addr_i : p0_addr_i;
                        mem_data_q <= grant_d ? p1_data_i : p0_data_i;
                        mem_we_q   <= grant_d ? p1_we_i : p0_we_i;
                        mem_cs_q   <= 1'b1;
                        state_q    <= BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_q     <= grant_d;
`endif
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_cs_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= RELEASE;
                        // Write-backs complete with an ack but leave the read line untouched.
                        if (grant_q == PORT_IFETCH) begin
                            p0_ack_q <= 1'b1;
                            if (!mem_we_q) p0_data_q <= mem_data_i;
                        end else begin
                            p1_ack_q <= 1'b1;
                            if (!mem_we_q) p1_data_q <= mem_data_i;
                        end
                    end
                end
                RELEASE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_cs_o   = mem_cs_q;
    assign mem_we_o   = mem_we_q;
    assign p0_data_o  = p0_data_q;
    assign p1_data_o  = p1_data_q;
    assign p0_ack_o   = p0_ack_q;
    assign p1_ack_o   = p1_ack_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (honours MEM_ARB_ROUND_ROBIN_EN)
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] p0_addr_i = '0, p1_addr_i = '0;
    logic [DW-1:0] p0_data_i = '0, p1_data_i = '0;
    logic          p0_cs_i = 1'b0, p0_we_i = 1'b0, p1_cs_i = 1'b0, p1_we_i = 1'b0;
    logic [DW-1:0] p0_data_o, p1_data_o;
    logic          p0_ack_o, p1_ack_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_cs_o, mem_we_o, busy_o;
    logic [DW-1:0] mem_data_i = '0;
    logic          dram_ack = 1'b0, tb_ack = 1'b0;
    wire           mem_ack_i = dram_ack | tb_ack;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i), .p0_cs_i(p0_cs_i), .p0_we_i(p0_we_i),
        .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
        .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_cs_i(p1_cs_i), .p1_we_i(p1_we_i),
        .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // DRAM model: acks after dram_delay cycles of chip select, data derived from the address.
    bit          dram_auto = 1'b0;
    int          dram_delay = 4;
    bit          dram_fixed_en = 1'b0;
    logic [DW-1:0] dram_fixed = '0;
    int          dram_cnt = 0;
    bit          dram_done = 1'b0;

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        return {8{a ^ 32'hC3A5_0F00}};
    endfunction

    initial forever begin
        @(negedge clk);
        dram_ack = 1'b0;
        if (!mem_cs_o) begin
            dram_cnt  = 0;
            dram_done = 1'b0;
        end else if (dram_auto && !dram_done) begin
            dram_cnt++;
            if (dram_cnt >= dram_delay) begin
                dram_ack   = 1'b1;
                mem_data_i = dram_fixed_en ? dram_fixed : line_of(mem_addr_o);
                dram_done  = 1'b1;
            end
        end
    end

    int p0_acks = 0;
    int p1_acks = 0;
    initial forever begin
        @(posedge clk);
        #2;
        if (p0_ack_o) p0_acks++;
        if (p1_ack_o) p1_acks++;
    end

    // Reference state: expected read lines per port and last granted port.
    logic [DW-1:0] exp_data [2];
    int            model_last = 1;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick();
        exp_data[0] = '0;
        exp_data[1] = '0;
        checks++;
        if ({mem_cs_o, mem_we_o, busy_o, p0_ack_o, p1_ack_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {mem_cs_o, mem_we_o, busy_o, p0_ack_o, p1_ack_o});
        end
        checks++;
        if (mem_addr_o !== '0 || mem_data_o !== '0) begin
            errors++;
            $display("FAIL reset_mem_bus: addr %h data %h want 0", mem_addr_o, mem_data_o);
        end
        checks++;
        if (p0_data_o !== '0 || p1_data_o !== '0) begin
            errors++;
            $display("FAIL reset_port_data: p0 %h p1 %h want 0", p0_data_o, p1_data_o);
        end
    endtask

    task automatic test_single_read();
        int c0 = p0_acks;
        int cnt = 0;
        bit got = 1'b0;
        dram_auto = 1'b1; dram_delay = 10; dram_fixed_en = 1'b1; dram_fixed = 256'h5;
        p1_addr_i = 32'h20; p1_we_i = 1'b0; p1_cs_i = 1'b1;
        tick();
        checks++;
        if (mem_cs_o !== 1'b1 || mem_addr_o !== 32'h20) begin
            errors++;
            $display("FAIL single_grant_latency: cs %b addr %h want 1 00000020", mem_cs_o, mem_addr_o);
        end
        cnt = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (p1_ack_o) begin got = 1'b1; break; end
            if (mem_cs_o) cnt++;
        end
        p1_cs_i = 1'b0;
        checks++;
        if (!got || cnt !== 10) begin
            errors++;
            $display("FAIL single_cs_width: ack %b cs_cycles %0d want 1 10", got, cnt);
        end
        exp_data[1] = 256'h5;
        checks++;
        if (p1_data_o !== exp_data[1]) begin
            errors++;
            $display("FAIL single_data: got %h want %h", p1_data_o, exp_data[1]);
        end
        tick();
        checks++;
        if (p1_ack_o !== 1'b0 || p0_acks !== c0) begin
            errors++;
            $display("FAIL single_ack_pulse: p1_ack %b p0_acks %0d want 0 %0d", p1_ack_o, p0_acks, c0);
        end
        dram_fixed_en = 1'b0;
        model_last = 1;
        tick(2);
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] wd = {8{$urandom()}};
        int rel = 0;
        bit got = 1'b0;
        dram_auto = 1'b1; dram_delay = 3;
        p0_addr_i = 32'h0;   p0_we_i = 1'b0; p0_cs_i = 1'b1;
        p1_addr_i = 32'h400; p1_we_i = 1'b1; p1_data_i = wd; p1_cs_i = 1'b1;
        tick();
        checks++;
        if (mem_cs_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL simul_first_p0: cs %b we %b addr %h want 1 0 00000000", mem_cs_o, mem_we_o, mem_addr_o);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            if (p0_ack_o) begin got = 1'b1; break; end
        end
        p0_cs_i = 1'b0;
        exp_data[0] = line_of(32'h0);
        checks++;
        if (!got || p1_ack_o !== 1'b0 || p0_data_o !== exp_data[0]) begin
            errors++;
            $display("FAIL simul_p0_done: ack %b p1_ack %b data %h want 1 0 %h", got, p1_ack_o, p0_data_o, exp_data[0]);
        end
        for (int i = 0; i < 20; i++) begin
            if (mem_cs_o) break;
            if (busy_o) rel++;
            tick();
        end
        checks++;
        if (rel !== 1) begin
            errors++;
            $display("FAIL simul_release_cycles: got %0d want 1", rel);
        end
        checks++;
        if (mem_cs_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h400 || mem_data_o !== wd) begin
            errors++;
            $display("FAIL simul_p1_write: cs %b we %b addr %h want 1 1 00000400", mem_cs_o, mem_we_o, mem_addr_o);
        end
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (p1_ack_o) begin got = 1'b1; break; end
        end
        p1_cs_i = 1'b0; p1_we_i = 1'b0;
        checks++;
        if (!got || p1_data_o !== exp_data[1]) begin
            errors++;
            $display("FAIL simul_write_no_data: ack %b data %h want 1 %h", got, p1_data_o, exp_data[1]);
        end
        model_last = 1;
        tick(2);
    endtask

    task automatic test_round_robin();
        int ord [4];
        int n = 0;
        int c1 = p1_acks;
        int exp_p;
        dram_auto = 1'b1; dram_delay = $urandom_range(1, 4);
        p0_addr_i = 32'h40; p0_we_i = 1'b0;
        p1_addr_i = 32'h80; p1_we_i = 1'b0;
        p0_cs_i = 1'b1; p1_cs_i = 1'b1;
        for (int i = 0; i < 400 && n < 4; i++) begin
            tick();
            if (p0_ack_o) begin ord[n] = 0; n++; end
            else if (p1_ack_o) begin ord[n] = 1; n++; end
        end
        p0_cs_i = 1'b0; p1_cs_i = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL rr_count: got %0d want 4", n);
        end
        for (int k = 0; k < n; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_p = (model_last == 1) ? 0 : 1;
`else
            exp_p = 0;
`endif
            model_last = exp_p;
            checks++;
            if (ord[k] !== exp_p) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d want %0d", k, ord[k], exp_p);
            end
        end
        exp_data[0] = line_of(32'h40);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_data[1] = line_of(32'h80);
        checks++;
        if (p1_acks - c1 !== 2) begin
            errors++;
            $display("FAIL rr_p1_acks: got %0d want 2", p1_acks - c1);
        end
`else
        checks++;
        if (p1_acks - c1 !== 0) begin
            errors++;
            $display("FAIL rr_p1_starved: got %0d want 0", p1_acks - c1);
        end
`endif
        tick(3);
    endtask

    task automatic test_stray_ack();
        int c0 = p0_acks;
        int c1 = p1_acks;
        tick(2);
        tb_ack = 1'b1;
        tick();
        tb_ack = 1'b0;
        tick(3);
        checks++;
        if (p0_acks !== c0 || p1_acks !== c1 || busy_o !== 1'b0 || mem_cs_o !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: acks %0d/%0d busy %b cs %b want %0d/%0d 0 0",
                     p0_acks, p1_acks, busy_o, mem_cs_o, c0, c1);
        end
    endtask

    task automatic test_early_drop();
        int c0 = p0_acks;
        bit got = 1'b0;
        dram_auto = 1'b1; dram_delay = 8;
        p0_addr_i = 32'h1000; p0_we_i = 1'b0; p0_cs_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_cs_o) break;
        end
        tick(2);
        p0_cs_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (p0_ack_o) begin got = 1'b1; break; end
        end
        exp_data[0] = line_of(32'h1000);
        checks++;
        if (!got || p0_data_o !== exp_data[0]) begin
            errors++;
            $display("FAIL early_drop_complete: ack %b data %h want 1 %h", got, p0_data_o, exp_data[0]);
        end
        tick(4);
        checks++;
        if (p0_acks - c0 !== 1 || busy_o !== 1'b0 || mem_cs_o !== 1'b0) begin
            errors++;
            $display("FAIL early_drop_idle: acks %0d busy %b cs %b want 1 0 0", p0_acks - c0, busy_o, mem_cs_o);
        end
        model_last = 0;
    endtask

    task automatic test_random();
        bit            pend [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        bit            w [2];
        int            win, oth, c_oth;
        bit            got, latch_bad;
        pend[0] = 1'b0; pend[1] = 1'b0;
        dram_auto = 1'b1;
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    a[p] = $urandom() & 32'hFFFF_FFE0;
                    d[p] = {8{$urandom()}};
                    w[p] = $urandom_range(0, 1);
                end
            end
            if (!pend[0] && !pend[1]) begin
                win = $urandom_range(0, 1);
                pend[win] = 1'b1; a[win] = $urandom() & 32'hFFFF_FFE0;
                d[win] = {8{$urandom()}}; w[win] = 1'b0;
            end
            p0_addr_i = a[0]; p0_data_i = d[0]; p0_we_i = w[0]; p0_cs_i = pend[0];
            p1_addr_i = a[1]; p1_data_i = d[1]; p1_we_i = w[1]; p1_cs_i = pend[1];
            if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                win = 1 - model_last;
`else
                win = 0;
`endif
            end else begin
                win = pend[1] ? 1 : 0;
            end
            oth = 1 - win;
            model_last = win;
            dram_delay = $urandom_range(1, 6);
            c_oth = (oth == 0) ? p0_acks : p1_acks;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (mem_cs_o) begin got = 1'b1; break; end
            end
            checks++;
            if (!got || mem_addr_o !== a[win] || mem_we_o !== w[win] || (w[win] && mem_data_o !== d[win])) begin
                errors++;
                $display("FAIL rand_grant[%0d]: cs %b addr %h we %b want port %0d addr %h we %b",
                         t, got, mem_addr_o, mem_we_o, win, a[win], w[win]);
            end
            if (win == 0) begin p0_addr_i = $urandom(); p0_we_i = ~w[0]; p0_data_i = '1; end
            else          begin p1_addr_i = $urandom(); p1_we_i = ~w[1]; p1_data_i = '1; end
            got = 1'b0; latch_bad = 1'b0;
            for (int i = 0; i < 30; i++) begin
                tick();
                if ((win == 0 && p0_ack_o) || (win == 1 && p1_ack_o)) begin got = 1'b1; break; end
                if (mem_cs_o && (mem_addr_o !== a[win] || mem_we_o !== w[win])) latch_bad = 1'b1;
            end
            if (!w[win]) exp_data[win] = line_of(a[win]);
            checks++;
            if (!got || latch_bad || ((oth == 0) ? p0_acks : p1_acks) !== c_oth) begin
                errors++;
                $display("FAIL rand_ack[%0d]: ack %b latch_bad %b other_acks %0d want 1 0 %0d", t, got, latch_bad,
                         (oth == 0) ? p0_acks : p1_acks, c_oth);
            end
            checks++;
            if (p0_data_o !== exp_data[0] || p1_data_o !== exp_data[1]) begin
                errors++;
                $display("FAIL rand_data[%0d]: p0 %h p1 %h want %h %h", t, p0_data_o, p1_data_o, exp_data[0], exp_data[1]);
            end
            pend[win] = 1'b0;
            if (win == 0) p0_cs_i = 1'b0; else p1_cs_i = 1'b0;
        end
        p0_cs_i = 1'b0; p1_cs_i = 1'b0;
        tick(4);
    endtask

    task automatic test_reset_mid();
        int c0, c1;
        dram_auto = 1'b0;
        p0_addr_i = 32'h2000; p0_we_i = 1'b0; p0_cs_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_cs_o) break;
        end
        tick(2);
        rst = 1'b1; p0_cs_i = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({mem_cs_o, mem_we_o, busy_o, p0_ack_o, p1_ack_o} !== 5'b0 || mem_addr_o !== '0 ||
            p0_data_o !== '0 || p1_data_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ctrl %b addr %h want 00000 0",
                     {mem_cs_o, mem_we_o, busy_o, p0_ack_o, p1_ack_o}, mem_addr_o);
        end
        c0 = p0_acks; c1 = p1_acks;
        tick(2);
        tb_ack = 1'b1;
        tick();
        tb_ack = 1'b0;
        tick(3);
        checks++;
        if (p0_acks !== c0 || p1_acks !== c1 || busy_o !== 1'b0 || mem_cs_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_late_ack: acks %0d/%0d busy %b want %0d/%0d 0", p0_acks, p1_acks, busy_o, c0, c1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_stray_ack();
        test_early_drop();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
